// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl: ioctl download router and core reset sequencer for the Bagman core.
//   clk_sys/reset_n : system clock, async active-low reset
//   ext_reset       : sync user/OSD reset request
//   ioctl_*         : hps_io download stream (index 0 ROM, 1 variant, 254 DIP)
//   dn_addr/data/wr : ROM loader port to the core
//   dipsw, mod_*    : captured DIP bytes and decoded board-variant flags
//   core_reset      : core held in reset except in RUN
//   rom_loaded      : a ROM image has been completely downloaded
//   rom_overflow    : sticky, a ROM byte beyond 2^ROM_AW was dropped
module rom_dl_ctrl #(
  parameter int ROM_AW = 17,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ext_reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [63:0]       dipsw,
  output logic              mod_sbag,
  output logic              mod_pick,
  output logic              mod_squa,
  output logic              core_reset,
  output logic              rom_loaded,
  output logic              rom_overflow
);
  localparam int CW = $clog2(HOLD_CYCLES);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] mod;
  logic rom_seen;
  logic load_wr, in_range, rom_wr, ovf_wr, mod_wr, dip_wr, reload;
  // Writes only count while in LOAD, so the strobe in the cycle the download
  // is first sampled is dropped, but the one in the falling cycle is kept.
  assign load_wr  = state == LOAD && ioctl_wr;
  assign in_range = ioctl_addr[24:ROM_AW] == '0;
  assign rom_wr   = load_wr && ioctl_index == 8'd0 && in_range;
  assign ovf_wr   = load_wr && ioctl_index == 8'd0 && !in_range;
  assign mod_wr   = load_wr && ioctl_index == 8'd1;
  assign dip_wr   = load_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == '0;
  // A fresh hold starts on entry to HOLD, and ext_reset restarts a running one.
  assign reload   = state_n == HOLD && (state != HOLD || ext_reset);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = ioctl_download ? LOAD : IDLE;
      LOAD:    state_n = ioctl_download ? LOAD : HOLD;
      HOLD:    state_n = ioctl_download ? LOAD : (ext_reset || cnt != '0) ? HOLD : rom_loaded ? RUN : IDLE;
      RUN:     state_n = ioctl_download ? LOAD : ext_reset ? HOLD : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_comb core_reset = state != RUN;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      cnt          <= '0;
      dn_addr      <= '0;
      dn_data      <= '0;
      dn_wr        <= 1'b0;
      dipsw        <= '0;
      mod          <= '0;
      mod_sbag     <= 1'b0;
      mod_pick     <= 1'b0;
      mod_squa     <= 1'b0;
      rom_seen     <= 1'b0;
      rom_loaded   <= 1'b0;
      rom_overflow <= 1'b0;
    end else begin
      cnt          <= reload ? CW'(HOLD_CYCLES - 1) : (state == HOLD && cnt != '0) ? cnt - CW'(1) : cnt;
      dn_wr        <= rom_wr;
      dn_addr      <= rom_wr ? ioctl_addr[ROM_AW-1:0] : dn_addr;
      dn_data      <= rom_wr ? ioctl_dout : dn_data;
      mod          <= mod_wr ? ioctl_dout : mod;
      mod_sbag     <= mod == 8'd1;
      mod_pick     <= mod == 8'd2;
      mod_squa     <= mod == 8'd3;
      rom_seen     <= (state != LOAD && state_n == LOAD) ? 1'b0 : rom_seen | rom_wr;
      // The same-cycle write is folded in so a byte on the falling edge counts.
      rom_loaded   <= rom_loaded | (state == LOAD && !ioctl_download && (rom_seen | rom_wr));
      rom_overflow <= rom_overflow | ovf_wr;
      for (int i = 0; i < 8; i++)
        if (dip_wr && ioctl_addr[2:0] == 3'(i)) dipsw[8*i +: 8] <= ioctl_dout;
    end
endmodule
